// File: rtl/pipe_stage_regs_pkg.sv
// Shared constants for the fetch/decode/execute pipeline registers.
//   NOP_INSTR        : canonical bubble instruction (addi x0, x0, 0)
//   RS1/RS2/RD_LSB   : bit positions of the register fields inside an instruction
//   REG_W            : register-number width
//   RESULT_SRC_LOAD  : ResultSrc encoding that marks a load
package pipe_stage_regs_pkg;

   localparam int          INSTR_W         = 32;
   localparam logic [31:0] NOP_INSTR       = 32'h0000_0013;
   localparam int          REG_W           = 5;
   localparam int          RS1_LSB         = 15;
   localparam int          RS2_LSB         = 20;
   localparam int          RD_LSB          = 7;
   localparam logic [1:0]  RESULT_SRC_LOAD = 2'b01;

endpackage

// File: rtl/pipe_stage_regs_reg.sv
// Generic pipeline register.
//   clk : rising-edge clock
//   rst : asynchronous active-low reset, loads RST_VAL
//   en  : load d on the next edge
//   clr : synchronous clear to RST_VAL, takes priority over en
//   d/q : data in / registered data out
module pipe_reg #(
   parameter int           W       = 1,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         clr,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] q_d;
   logic [W-1:0] q_q;

   always_comb begin
      q_d = q_q;
      if (clr) begin
         q_d = RST_VAL;
      end else if (en) begin
         q_d = d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q_q <= RST_VAL;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/pipe_stage_regs.sv
// PC, IF/ID and ID/EX registers driven by the hazard-unit controls.
//   Inputs : clk, rst (async active-low), StallF, StallD, FlushD, FlushE,
//            PCSrcE/PCTargetE (EX redirect), InstrF, RegWriteD, ResultSrcD
//   Outputs: PCF; IF/ID fields InstrD, PCD, ValidD and decoded Rs1D/Rs2D/RdD;
//            ID/EX fields RegWriteE, ResultSrcE, Rs1E, Rs2E, RdE, PCE, ValidE;
//            saturating StallCnt (IF/ID held) and FlushCnt (ID/EX flushed)
module pipe_stage_regs
   import pipe_stage_regs_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int              CNT_W    = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 StallF,
   input  logic                 StallD,
   input  logic                 FlushD,
   input  logic                 FlushE,
   input  logic                 PCSrcE,
   input  logic [XLEN-1:0]      PCTargetE,
   input  logic [INSTR_W-1:0]   InstrF,
   input  logic                 RegWriteD,
   input  logic [1:0]           ResultSrcD,
   output logic [XLEN-1:0]      PCF,
   output logic [INSTR_W-1:0]   InstrD,
   output logic [XLEN-1:0]      PCD,
   output logic [REG_W-1:0]     Rs1D,
   output logic [REG_W-1:0]     Rs2D,
   output logic [REG_W-1:0]     RdD,
   output logic                 ValidD,
   output logic                 RegWriteE,
   output logic [1:0]           ResultSrcE,
   output logic [REG_W-1:0]     Rs1E,
   output logic [REG_W-1:0]     Rs2E,
   output logic [REG_W-1:0]     RdE,
   output logic [XLEN-1:0]      PCE,
   output logic                 ValidE,
   output logic [CNT_W-1:0]     StallCnt,
   output logic [CNT_W-1:0]     FlushCnt
);

   localparam int IFID_W = INSTR_W + XLEN + 1;
   localparam int IDEX_W = 1 + 2 + 3 * REG_W + XLEN + 1;
   localparam logic [IFID_W-1:0] IFID_RST = {NOP_INSTR, {XLEN{1'b0}}, 1'b0};
   localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

   // ---------------- PC register ----------------
   // A redirect must win over a fetch stall, so it also forces the enable.
   logic [XLEN-1:0] pc_next;
   assign pc_next = PCSrcE ? PCTargetE : (PCF + XLEN'(4));

   pipe_reg #(.W(XLEN), .RST_VAL(RESET_PC)) u_pc_reg (
      .clk (clk),
      .rst (rst),
      .en  (PCSrcE | ~StallF),
      .clr (1'b0),
      .d   (pc_next),
      .q   (PCF)
   );

   // ---------------- IF/ID register ----------------
   // Flush clears to the reset image (NOP, PC 0, invalid) and beats a stall.
   logic [IFID_W-1:0] ifid_q;

   pipe_reg #(.W(IFID_W), .RST_VAL(IFID_RST)) u_ifid_reg (
      .clk (clk),
      .rst (rst),
      .en  (~StallD),
      .clr (FlushD),
      .d   ({InstrF, PCF, 1'b1}),
      .q   (ifid_q)
   );

   assign {InstrD, PCD, ValidD} = ifid_q;
   assign Rs1D = InstrD[RS1_LSB +: REG_W];
   assign Rs2D = InstrD[RS2_LSB +: REG_W];
   assign RdD  = InstrD[RD_LSB  +: REG_W];

   // ---------------- ID/EX register ----------------
   // No stall input: it reloads every cycle. The all-zero bubble has RdE=0
   // and a non-load ResultSrcE, so it never matches a forwarding/load-use check.
   logic [IDEX_W-1:0] idex_q;

   pipe_reg #(.W(IDEX_W), .RST_VAL('0)) u_idex_reg (
      .clk (clk),
      .rst (rst),
      .en  (1'b1),
      .clr (FlushE),
      .d   ({RegWriteD, ResultSrcD, Rs1D, Rs2D, RdD, PCD, ValidD}),
      .q   (idex_q)
   );

   assign {RegWriteE, ResultSrcE, Rs1E, Rs2E, RdE, PCE, ValidE} = idex_q;

   // ---------------- event counters ----------------
   // A stall overridden by a flush is not counted as a held cycle.
   logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;
   logic [CNT_W-1:0] flush_cnt_d, flush_cnt_q;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (StallD && !FlushD && (stall_cnt_q != CNT_MAX)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      if (FlushE && (flush_cnt_q != CNT_MAX)) begin
         flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign StallCnt = stall_cnt_q;
   assign FlushCnt = flush_cnt_q;

endmodule
